// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//   Receive-side health monitor for a divided clock generated in the clkin
//   domain. It samples div_in on clkin and measures the rising-edge-to-rising-edge
//   period and the sampled high time, both in clkin cycles. After LOCK_COUNT
//   consecutive periods within TOL of EXP_PERIOD it asserts locked. It raises
//   sticky flags for a bad period seen while locked and for a missing edge
//   (stall).
//
// Ports
//   clkin        : sole clock, all logic on posedge
//   reset        : synchronous, active-high
//   enable       : 1 = monitor runs, 0 = return to IDLE (sticky flags kept)
//   div_in       : divided clock under test
//   clr_err      : one-cycle pulse clearing err_period and stall
//   period       : last measured period (clkin cycles)
//   high_time    : sampled high cycles within that period
//   period_valid : one-cycle pulse when period/high_time update
//   locked       : ratio confirmed
//   err_period   : sticky, bad period or stall while locked
//   stall        : sticky, no rising edge for TIMEOUT cycles
module clk_div_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = 3,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned SYNC_EN    = 1
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             err_period,
  output logic             stall
);

  localparam int unsigned XW   = CNT_W + 1;
  localparam int unsigned GC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [XW-1:0]    EXP_C     = XW'(EXP_PERIOD);
  localparam logic [XW-1:0]    TOL_C     = XW'(TOL);
  localparam logic [GC_W-1:0]  LOCK_C    = GC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    MEASURE,
    LOCKED
  } state_t;

  // ---------------------------------------------------------------------------
  // Input stage
  // ---------------------------------------------------------------------------
  logic s;

  if (SYNC_EN != 0) begin : g_sync
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
      sync_d = {sync_q[0], div_in};
    end

    always_ff @(posedge clkin) begin
      if (reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign s = sync_q[1];
  end else begin : g_direct
    assign s = div_in;
  end

  logic s_d_q;
  logic rise;
  logic fall;

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  state_t           state_q,        state_d;
  logic [CNT_W-1:0] per_cnt_q,      per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q,       hi_cnt_d;
  logic [CNT_W-1:0] hi_lat_q,       hi_lat_d;
  logic [GC_W-1:0]  good_cnt_q,     good_cnt_d;
  logic [CNT_W-1:0] period_q,       period_d;
  logic [CNT_W-1:0] high_time_q,    high_time_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q,       locked_d;
  logic             err_period_q,   err_period_d;
  logic             stall_q,        stall_d;

  // Deviation is taken in CNT_W+1 bits so neither subtraction can wrap.
  logic [XW-1:0]   meas_ext;
  logic [XW-1:0]   dev;
  logic            good;
  logic [GC_W-1:0] good_cnt_inc;

  always_comb begin
    meas_ext     = {1'b0, per_cnt_q};
    dev          = (meas_ext >= EXP_C) ? (meas_ext - EXP_C) : (EXP_C - meas_ext);
    good         = (dev <= TOL_C);
    good_cnt_inc = good_cnt_q + 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    per_cnt_d      = per_cnt_q;
    hi_cnt_d       = hi_cnt_q;
    hi_lat_d       = hi_lat_q;
    good_cnt_d     = good_cnt_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    // Clear first; any set event below overrides it in the same cycle.
    err_period_d   = err_period_q & ~clr_err;
    stall_d        = stall_q & ~clr_err;

    if (!enable) begin
      state_d    = IDLE;
      locked_d   = 1'b0;
      good_cnt_d = '0;
      per_cnt_d  = '0;
      hi_cnt_d   = '0;
      hi_lat_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ACQUIRE;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
        end

        ACQUIRE: begin
          // The first edge only starts the counters; no period exists yet.
          if (rise) begin
            state_d   = MEASURE;
            per_cnt_d = CNT_W'(1);
            hi_cnt_d  = CNT_W'(1);
          end
        end

        MEASURE, LOCKED: begin
          if (rise) begin
            period_d       = per_cnt_q;
            high_time_d    = hi_lat_q;
            period_valid_d = 1'b1;
            per_cnt_d      = CNT_W'(1);
            hi_cnt_d       = CNT_W'(1);
            if (state_q == MEASURE) begin
              if (good) begin
                good_cnt_d = good_cnt_inc;
                if (good_cnt_inc == LOCK_C) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                end
              end else begin
                good_cnt_d = '0;
              end
            end else if (!good) begin
              err_period_d = 1'b1;
              locked_d     = 1'b0;
              good_cnt_d   = '0;
              state_d      = MEASURE;
            end
          end else if (per_cnt_q == TIMEOUT_C) begin
            // Stuck high and stuck low both land here.
            stall_d    = 1'b1;
            locked_d   = 1'b0;
            good_cnt_d = '0;
            per_cnt_d  = '0;
            hi_cnt_d   = '0;
            state_d    = ACQUIRE;
            if (state_q == LOCKED) begin
              err_period_d = 1'b1;
            end
          end else begin
            per_cnt_d = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + 1'b1;
            if (s) begin
              hi_cnt_d = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + 1'b1;
            end
            if (fall) begin
              hi_lat_d = hi_cnt_q;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q        <= IDLE;
      s_d_q          <= 1'b0;
      per_cnt_q      <= '0;
      hi_cnt_q       <= '0;
      hi_lat_q       <= '0;
      good_cnt_q     <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_period_q   <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_d_q          <= s;
      per_cnt_q      <= per_cnt_d;
      hi_cnt_q       <= hi_cnt_d;
      hi_lat_q       <= hi_lat_d;
      good_cnt_q     <= good_cnt_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      err_period_q   <= err_period_d;
      stall_q        <= stall_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err_period   = err_period_q;
  assign stall        = stall_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor
//   Directed bench for clk_div_monitor. Two instances share stimulus: u_dut0
//   samples div_in directly (SYNC_EN=0) and u_dut1 uses the 2-flop
//   synchronizer (SYNC_EN=1), so its results appear 2 cycles later.
module tb_clk_div_monitor;

  logic       clkin = 1'b0;
  logic       reset;
  logic       enable;
  logic       div_in;
  logic       clr_err;

  logic [7:0] period0, high_time0, period1, high_time1;
  logic       pv0, locked0, err0, stall0;
  logic       pv1, locked1, err1, stall1;

  int n_checks = 0;
  int n_errors = 0;

  // Values captured on the rising-edge tick of gen_period (u_dut0).
  logic       r_pv, r_lock, r_err;
  logic [7:0] r_per, r_hi;

  always #5 clkin = ~clkin;

  clk_div_monitor #(.SYNC_EN(0)) u_dut0 (
    .clkin(clkin), .reset(reset), .enable(enable), .div_in(div_in),
    .clr_err(clr_err), .period(period0), .high_time(high_time0),
    .period_valid(pv0), .locked(locked0), .err_period(err0), .stall(stall0)
  );

  clk_div_monitor #(.SYNC_EN(1)) u_dut1 (
    .clkin(clkin), .reset(reset), .enable(enable), .div_in(div_in),
    .clr_err(clr_err), .period(period1), .high_time(high_time1),
    .period_valid(pv1), .locked(locked1), .err_period(err1), .stall(stall1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clkin cycle with div_in = d; outputs are read 1 ns after the edge.
  task automatic tick(input logic d);
    div_in = d;
    @(posedge clkin);
    #1;
  endtask

  // One div_in period: hi ones then (len-hi) zeros. clr is applied only on
  // the rising-edge tick, where u_dut0's outputs are captured.
  task automatic gen_period(input int len, input int hi, input logic clr);
    for (int k = 0; k < len; k++) begin
      clr_err = (k == 0) ? clr : 1'b0;
      tick(k < hi);
      if (k == 0) begin
        r_pv   = pv0;
        r_per  = period0;
        r_hi   = high_time0;
        r_lock = locked0;
        r_err  = err0;
      end
    end
    clr_err = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    div_in  = 1'b0;
    clr_err = 1'b0;

    // Reset state
    tick(1'b0);
    tick(1'b0);
    check("rst_period", period0, 0);
    check("rst_high", high_time0, 0);
    check("rst_pv", pv0, 0);
    check("rst_locked", locked0, 0);
    check("rst_err", err0, 0);
    check("rst_stall", stall0, 0);

    // Leave reset, IDLE -> ACQUIRE with div_in low.
    reset  = 1'b0;
    enable = 1'b1;
    tick(1'b0);

    // Scenario 1: div_in = 1,1,0 repeating. u_dut0 sees rises at i=0,3,6,..;
    // u_dut1 at i=2,5,8,.. The first rise only starts counting.
    for (int i = 0; i < 18; i++) begin
      tick((i % 3) != 2);
      check("s1_pv0", pv0, (i % 3 == 0) && (i >= 3));
      check("s1_lock0", locked0, i >= 12);
      check("s1_pv1", pv1, (i % 3 == 2) && (i >= 5));
      check("s1_lock1", locked1, i >= 14);
      if ((i % 3 == 0) && (i >= 3)) begin
        check("s1_period0", period0, 3);
        check("s1_high0", high_time0, 2);
      end
      if ((i % 3 == 2) && (i >= 5)) begin
        check("s1_period1", period1, 3);
        check("s1_high1", high_time1, 2);
      end
    end
    check("s1_err0", err0, 0);
    check("s1_stall0", stall0, 0);
    check("s1_err1", err1, 0);

    // Scenario 2: one stretched period (1,1,0,0) while locked.
    gen_period(4, 2, 1'b0);
    check("s2_pre_pv", r_pv, 1);
    check("s2_pre_lock", r_lock, 1);
    gen_period(3, 2, 1'b0);
    check("s2_bad_pv", r_pv, 1);
    check("s2_bad_period", r_per, 4);
    check("s2_bad_high", r_hi, 2);
    check("s2_bad_lock", r_lock, 0);
    check("s2_bad_err", r_err, 1);
    gen_period(3, 2, 1'b0);
    gen_period(3, 2, 1'b0);
    gen_period(3, 2, 1'b0);
    check("s2_relock3", r_lock, 0);
    gen_period(3, 2, 1'b0);
    check("s2_relock4", r_lock, 1);
    check("s2_err_sticky", r_err, 1);
    gen_period(3, 2, 1'b1);
    check("s2_clr_err", r_err, 0);
    check("s2_clr_lock", r_lock, 1);

    // Scenario 3: div_in held low while locked. The last rise was 2 ticks
    // before the hold, so u_dut0 stalls on hold tick 14, u_dut1 on tick 16.
    for (int h = 1; h <= 16; h++) begin
      tick(1'b0);
      if (h == 13) begin
        check("s3_stall_early", stall0, 0);
        check("s3_lock_early", locked0, 1);
      end
      if (h == 14) begin
        check("s3_stall", stall0, 1);
        check("s3_err", err0, 1);
        check("s3_lock", locked0, 0);
        check("s3_stall1_early", stall1, 0);
      end
      if (h == 16) begin
        check("s3_stall1", stall1, 1);
      end
    end
    gen_period(3, 2, 1'b0);
    check("s3_resume_pv", r_pv, 0);
    for (int p = 1; p <= 4; p++) begin
      gen_period(3, 2, 1'b0);
      check("s3_resume_pv_n", r_pv, 1);
      check("s3_relock", r_lock, p == 4);
    end
    check("s3_stall_sticky", stall0, 1);

    // Scenario 4: enable dropped mid-lock.
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick((i % 3) != 2);
      check("s4_off_pv", pv0, 0);
      check("s4_off_lock", locked0, 0);
    end
    check("s4_off_stall", stall0, 1);
    enable = 1'b1;
    tick(1'b0);
    for (int p = 1; p <= 5; p++) begin
      gen_period(3, 2, 1'b0);
      check("s4_pv", r_pv, p >= 2);
      check("s4_lock", r_lock, p == 5);
    end

    // Scenario 6: clr_err coinciding with a bad period keeps err_period set.
    gen_period(4, 2, 1'b0);
    gen_period(3, 2, 1'b1);
    check("s6_setwins_err", r_err, 1);
    check("s6_setwins_period", r_per, 4);
    check("s6_setwins_lock", r_lock, 0);
    for (int p = 1; p <= 4; p++) begin
      gen_period(3, 2, 1'b0);
    end
    check("s6_relock", r_lock, 1);
    check("s6_err_before_rst", err0, 1);

    // Reset while locked with err_period set.
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    check("s6_rst_period", period0, 0);
    check("s6_rst_high", high_time0, 0);
    check("s6_rst_pv", pv0, 0);
    check("s6_rst_lock", locked0, 0);
    check("s6_rst_err", err0, 0);
    check("s6_rst_stall", stall0, 0);
    check("s6_rst_err1", err1, 0);
    check("s6_rst_lock1", locked1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Receive-side checker for divided clocks generated in the clkin domain, such as the divide-by-3 output.
- Samples a divided-clock input with clkin and measures rising-edge-to-rising-edge period and sampled high time in clkin cycles.
- Declares lock after a run of periods matching the expected ratio, and flags ratio errors and stalls.
- Sits beside clock dividers as a built-in health monitor; its status outputs feed a status register block.

Parameters:
- CNT_W, 8, width of the period/high-time counters and outputs.
- EXP_PERIOD, 3, expected period in clkin cycles.
- TOL, 0, allowed absolute deviation of a measured period from EXP_PERIOD.
- LOCK_COUNT, 4, consecutive good periods required to assert locked.
- TIMEOUT, 16, cycles without a rising edge before a stall is declared; must be ≤ 2^CNT_W-1.
- SYNC_EN, 1, 1 = 2-flop synchronizer on div_in; 0 = direct sampling for same-domain sources.

Ports:
- clkin, input, 1, sole clock; all logic on the posedge.
- reset, input, 1, synchronous, active-high reset.
- enable, input, 1, 1 = monitor runs; 0 = return to IDLE.
- div_in, input, 1, divided clock under test.
- clr_err, input, 1, one-cycle pulse that clears the sticky err_period and stall flags.
- period, output, CNT_W, last measured period in clkin cycles.
- high_time, output, CNT_W, sampled high cycles within that period.
- period_valid, output, 1, one-cycle pulse when period/high_time update.
- locked, output, 1, ratio confirmed.
- err_period, output, 1, sticky: a bad period or stall occurred while locked.
- stall, output, 1, sticky: no rising edge for TIMEOUT cycles.

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE. reset overrides every other input.
- Input stage:
  - s is div_in, after 2 flops if SYNC_EN=1.
  - s_d is s delayed by one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Latency from a div_in edge to rise: 1 cycle (SYNC_EN=0) or 3 cycles (SYNC_EN=1).
- per_cnt:
  - On rise, loads 1.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - On rise, the pre-update per_cnt is the measured period.
- hi_cnt:
  - On rise, loads 1.
  - Otherwise increments while s=1, with saturation.
  - On fall, hi_lat <= hi_cnt.
- good = |measured period - EXP_PERIOD| ≤ TOL, computed in CNT_W+1 bits with no wrap.
- FSM states: IDLE, ACQUIRE, MEASURE, LOCKED.
  - enable=0 from any state: next state IDLE; locked<=0; good_cnt and counters cleared; sticky flags retained.
  - IDLE and enable=1: next state ACQUIRE.
  - ACQUIRE, on the first rise: next state MEASURE; counters start; no period_valid.
  - MEASURE, on rise:
    - period<=measured, high_time<=hi_lat, period_valid=1.
    - If good: good_cnt+1. When it reaches LOCK_COUNT, go to LOCKED and set locked<=1.
    - If not good: good_cnt<=0.
  - LOCKED, on rise: same period/high_time/period_valid update.
    - Bad period: err_period<=1, locked<=0, good_cnt<=0, next state MEASURE.
  - MEASURE/LOCKED with per_cnt == TIMEOUT and no rise:
    - stall<=1, locked<=0, good_cnt<=0, next state ACQUIRE.
    - If in LOCKED, also err_period<=1.
    - No period_valid.
- Registered outputs:
  - period_valid, period and high_time are visible the cycle after the cycle in which rise is asserted.
  - locked rises in that same cycle, for the rise that completes LOCK_COUNT.
- clr_err and a set event in the same cycle: set wins.
- stall does not clear itself; only clr_err or reset clears it.
- div_in stuck high or low: both are timeouts, handled identically.
- A high phase longer than the period is impossible; hi_cnt saturation covers the stuck-high case.

Test Plan:
- SYNC_EN=0, enable=1, div_in repeating 1,1,0 from cycle 0 → first period_valid after the 2nd rise with period=3, high_time=2. locked=1 the cycle after the 5th rise; err_period=0; stall=0.
- Locked, then one period stretched to 4 (1,1,0,0) → period_valid with period=4, locked=0, err_period=1. Relock after 4 further good periods; err_period stays 1 until a clr_err pulse.
- Locked, then div_in held 0 → 16 cycles after the last rise: stall=1, err_period=1, locked=0, state ACQUIRE. Resuming 1,1,0 relocks; the first rise after resuming gives no period_valid.
- enable dropped mid-lock → locked=0 next cycle and no period_valid while low. Re-enable needs ACQUIRE plus 5 rises to lock.
- SYNC_EN=1, same stimulus as scenario 1 → identical period/high_time values, every output delayed exactly 2 cycles versus SYNC_EN=0.
- reset asserted while locked with err_period=1 → next cycle all outputs 0; clr_err and a bad period in the same cycle leave err_period=1.
